// File: rtl/adf4158_write_arbiter.sv
// Round-robin arbiter for two 32-bit register-write requesters sharing the ADF4158
// CLK/DATA/LE programming port; each accepted word goes out MSB-first inside one LE-low frame.
module adf4158_write_arbiter #(
   parameter int HALF_PER       = 1,
   parameter int LE_HIGH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   input  logic        inhibit,
   output logic        busy,
   output logic        grant_id,
   output logic        done,
   output logic        sclk,
   output logic        data,
   output logic        le
);

   localparam int PW = $clog2(HALF_PER + 1);
   localparam int LW = $clog2(LE_HIGH_CYCLES + 1);
   localparam logic [PW-1:0] PH_LOAD = PW'(HALF_PER - 1);
   localparam logic [LW-1:0] LE_LOAD = LW'(LE_HIGH_CYCLES - 1);

   // state   | meaning
   // S_IDLE  | le high, waiting for a grant
   // S_SHIFT | le low, 32 bits clocked out, sclk low then high per bit
   // S_HOLD  | le low, sclk low for one half-period after the last bit
   // S_LATCH | le high for LE_HIGH_CYCLES, done on the final cycle
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HOLD, S_LATCH} state_t;

   state_t          state_q, state_d;
   logic [31:0]     shift_q, shift_d;
   logic [4:0]      bit_q, bit_d;
   logic [PW-1:0]   phase_q, phase_d;
   logic            high_q, high_d;
   logic [LW-1:0]   le_cnt_q, le_cnt_d;
   logic            last_grant_q, last_grant_d;
   logic            grant_id_q, grant_id_d;
   logic            sel;
   logic            accept_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         bit_q        <= '0;
         phase_q      <= '0;
         high_q       <= 1'b0;
         le_cnt_q     <= '0;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bit_q        <= bit_d;
         phase_q      <= phase_d;
         high_q       <= high_d;
         le_cnt_q     <= le_cnt_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bit_d        = bit_q;
      phase_d      = phase_q;
      high_d       = high_q;
      le_cnt_d     = le_cnt_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      done         = 1'b0;

      // with both pending, the requester that did not win last time goes next
      sel        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      accept_en  = (state_q == S_IDLE) && !inhibit && !rst;
      req0_ready = accept_en && req0_valid && !sel;
      req1_ready = accept_en && req1_valid && sel;

      case (state_q)
         S_IDLE: begin
            if (req0_ready || req1_ready) begin
               state_d      = S_SHIFT;
               shift_d      = sel ? req1_data : req0_data;
               bit_d        = 5'd31;
               phase_d      = PH_LOAD;
               high_d       = 1'b0;
               last_grant_d = sel;
               grant_id_d   = sel;
            end
         end
         S_SHIFT: begin
            if (phase_q == '0) begin
               phase_d = PH_LOAD;
               if (!high_q) begin
                  high_d = 1'b1;
               end else begin
                  high_d = 1'b0;
                  // the final bit stays on data through the hold phase
                  if (bit_q == 5'd0) begin
                     state_d = S_HOLD;
                  end else begin
                     bit_d   = bit_q - 5'd1;
                     shift_d = {shift_q[30:0], 1'b0};
                  end
               end
            end else begin
               phase_d = phase_q - PW'(1);
            end
         end
         S_HOLD: begin
            if (phase_q == '0) begin
               state_d  = S_LATCH;
               le_cnt_d = LE_LOAD;
            end else begin
               phase_d = phase_q - PW'(1);
            end
         end
         S_LATCH: begin
            if (le_cnt_q == '0) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               le_cnt_d = le_cnt_q - LW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // pins decode directly from registered state so a reset drives them to idle at once
   assign busy     = (state_q != S_IDLE);
   assign grant_id = grant_id_q;
   assign sclk     = (state_q == S_SHIFT) && high_q;
   assign data     = ((state_q == S_SHIFT) || (state_q == S_HOLD)) && shift_q[31];
   assign le       = (state_q == S_IDLE) || (state_q == S_LATCH);

endmodule

// File: tb/tb_adf4158_write_arbiter.sv
// Scoreboard bench for adf4158_write_arbiter: default-timing instance checked frame by frame by a
// monitor, plus a HALF_PER=3 / LE_HIGH_CYCLES=4 instance checked for serial timing.
module tb_adf4158_write_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req0_valid = 1'b0, req1_valid = 1'b0, inhibit = 1'b0;
   logic [31:0] req0_data = '0, req1_data = '0;
   logic        req0_ready, req1_ready, busy, grant_id, done, sclk, data, le;

   logic        b_req0_valid = 1'b0, b_req1_valid = 1'b0, b_inhibit = 1'b0;
   logic [31:0] b_req0_data = '0, b_req1_data = '0;
   logic        b_req0_ready, b_req1_ready, b_busy, b_grant_id, b_done, b_sclk, b_data, b_le;

   adf4158_write_arbiter dut_a (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .inhibit(inhibit), .busy(busy), .grant_id(grant_id), .done(done),
      .sclk(sclk), .data(data), .le(le)
   );

   adf4158_write_arbiter #(.HALF_PER(3), .LE_HIGH_CYCLES(4)) dut_b (
      .clk(clk), .rst(rst),
      .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
      .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
      .inhibit(b_inhibit), .busy(b_busy), .grant_id(b_grant_id), .done(b_done),
      .sclk(b_sclk), .data(b_data), .le(b_le)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        id;
      logic [31:0] word;
      bit          b2b;
   } exp_t;
   exp_t sb[$];

   // ---------------- monitor for the default-timing instance ----------------
   int          cyc = 0, t_grant = 0, last_done = 0, nbits = 0, nlow = 0;
   bit          in_frame = 0;
   logic        prev_sclk = 1'b0;
   logic [31:0] got = '0;
   exp_t        cur;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         in_frame  = 0;
         prev_sclk = 1'b0;
      end else begin
         if (in_frame) begin
            if (sclk && !prev_sclk) begin
               got = {got[30:0], data};
               nbits++;
            end
            if (!le) nlow++;
            if (done) begin
               chk("frame_word", got, cur.word);
               chk("frame_grant_id", grant_id, cur.id);
               chk("frame_sclk_edges", nbits, 32);
               chk("frame_le_low", nlow, 65);
               chk("grant_to_done", cyc - t_grant, 67);
               chk("busy_at_done", busy, 1);
               in_frame  = 0;
               last_done = cyc;
            end
         end
         if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
            chk("grant_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               chk("grant_requester", req1_ready, cur.id);
               if (cur.b2b) chk("idle_gap", cyc - last_done, 1);
               in_frame = 1;
               t_grant  = cyc;
               got      = '0;
               nbits    = 0;
               nlow     = 0;
            end
         end
         prev_sclk = sclk;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic id, input logic [31:0] word, input bit b2b);
      exp_t e;
      e.id = id; e.word = word; e.b2b = b2b;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input logic which);
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ((which ? req1_ready : req0_ready) === 1'b1) begin
            ok = 1;
            break;
         end
      end
      chk("ready_within_budget", ok, 1);
   endtask

   task automatic wait_done();
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ok = 1;
            break;
         end
      end
      chk("done_within_budget", ok, 1);
   endtask

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic write_one(input logic id, input logic [31:0] word);
      push(id, word, 0);
      if (id) begin req1_data = word; req1_valid = 1'b1; end
      else    begin req0_data = word; req0_valid = 1'b1; end
      wait_ready(id);
      next_edge();
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   // ---------------- HALF_PER=3 instance measurement ----------------
   task automatic check_slow_frame();
      logic [31:0] bword = '0;
      logic        bprev = 1'b0, ps = 1'b0;
      int run = 0, runs = 0, bad = 0, lowc = 0, highc = 0;
      bit closed = 0, seen_done = 0, ok = 0;
      b_req0_data  = 32'hA5C3_0F1E;
      b_req0_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (b_req0_ready === 1'b1) begin ok = 1; break; end
      end
      chk("slow_ready", ok, 1);
      next_edge();
      b_req0_valid = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (b_sclk && !bprev) bword = {bword[30:0], b_data};
         bprev = b_sclk;
         if (!b_le) begin
            lowc++;
            if (run == 0) begin
               run = 1;
               ps  = b_sclk;
            end else if (b_sclk == ps) begin
               run++;
            end else begin
               runs++;
               if (run != 3) bad++;
               run = 1;
               ps  = b_sclk;
            end
         end else if (lowc > 0) begin
            if (!closed) begin
               runs++;
               if (run != 3) bad++;
               closed = 1;
            end
            highc++;
            if (b_done) begin seen_done = 1; break; end
         end
      end
      chk("slow_done_seen", seen_done, 1);
      chk("slow_word", bword, 32'hA5C3_0F1E);
      chk("slow_le_low", lowc, 195);
      chk("slow_phase_runs", runs, 65);
      chk("slow_bad_phase_len", bad, 0);
      chk("slow_le_high_to_done", highc, 4);
      chk("slow_grant_id", b_grant_id, 0);
      next_edge();
      chk("slow_busy_after", b_busy, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int n0, n1;
      bit ok;

      // reset values, including ready suppressed while reset is held
      req0_valid = 1'b1;
      req0_data  = 32'h1;
      repeat (3) @(negedge clk);
      chk("rst_sclk", sclk, 0);
      chk("rst_data", data, 0);
      chk("rst_le", le, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      req0_valid = 1'b0;
      next_edge();
      rst = 1'b0;
      repeat (2) next_edge();

      // single R0 write
      write_one(1'b0, 32'h8023_0000);
      wait_done();
      next_edge();
      chk("single_busy_after", busy, 0);

      // inhibit blocks a pending request, release grants it, raising mid-frame is ignored
      push(1'b1, 32'h1111_0002, 0);
      inhibit    = 1'b1;
      req1_data  = 32'h1111_0002;
      req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("inhibit_no_ready", req1_ready, 0);
         chk("inhibit_le_high", le, 1);
      end
      next_edge();
      inhibit = 1'b0;
      @(negedge clk);
      chk("inhibit_release_ready", req1_ready, 1);
      next_edge();
      req1_valid = 1'b0;
      repeat (20) next_edge();
      inhibit = 1'b1;
      wait_done();
      next_edge();
      inhibit = 1'b0;

      // contention: last grant was requester 1, so order is 0,1,0,1 back to back
      push(1'b0, 32'h0000_0003, 0);
      push(1'b1, 32'h0000_0004, 1);
      push(1'b0, 32'h0000_0003, 1);
      push(1'b1, 32'h0000_0004, 1);
      req0_data = 32'h0000_0003; req0_valid = 1'b1;
      req1_data = 32'h0000_0004; req1_valid = 1'b1;
      n0 = 0; n1 = 0;
      for (int g = 0; g < 4; g++) begin
         ok = 0;
         for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin ok = 1; break; end
         end
         chk("contention_grant_budget", ok, 1);
         if (req0_ready) n0++; else n1++;
         next_edge();
         if (n0 == 2) req0_valid = 1'b0;
         if (n1 == 2) req1_valid = 1'b0;
      end
      wait_done();
      next_edge();

      // withdrawn request while busy: no ready, no extra frame
      write_one(1'b1, 32'h2222_0006);
      repeat (10) next_edge();
      req0_data  = 32'h3333_0007;
      req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("withdrawn_no_ready", req0_ready, 0);
      end
      next_edge();
      req0_valid = 1'b0;
      wait_done();
      repeat (80) next_edge();
      chk("withdrawn_idle_busy", busy, 0);
      chk("withdrawn_idle_le", le, 1);

      // asynchronous reset at bit 16 (high phase, data bit 15 = 1)
      write_one(1'b0, 32'h1234_F678);
      repeat (33) @(posedge clk);
      #2;
      chk("pre_rst_sclk", sclk, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_le", le, 1);
      chk("async_rst_sclk", sclk, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_data", data, 0);
      repeat (2) next_edge();
      rst = 1'b0;
      next_edge();
      write_one(1'b1, 32'h0000_0005);
      wait_done();
      next_edge();

      check_slow_frame();

      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
